// File: rtl/bf16_sub.sv
// rtl/bf16_sub.sv - multi-cycle BFloat16 subtractor (a - b), serial align/subtract/normalize/round
//
// Ports:
//   clk, nreset              clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o        operand pair handshake; ready_o is high only in IDLE
//   sa_i, ea_i, ma_i         minuend a: sign, exponent, 7-bit mantissa
//   sb_i, eb_i, mb_i         subtrahend b: sign, exponent, 7-bit mantissa
//   valid_o / ready_i        result handshake; valid_o is high only in DONE
//   s_o, e_o, m_o            registered result, held stable while valid_o is high
module bf16_sub #(
    parameter int ALIGN_MAX = 10
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       valid_i,
    output logic       ready_o,
    input  logic       sa_i,
    input  logic [7:0] ea_i,
    input  logic [6:0] ma_i,
    input  logic       sb_i,
    input  logic [7:0] eb_i,
    input  logic [6:0] mb_i,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       s_o,
    output logic [7:0] e_o,
    output logic [6:0] m_o
);

    localparam int CW = $clog2(ALIGN_MAX + 2);
    localparam logic [15:0] QNAN = {1'b0, 8'hFF, 7'h40};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t         state;
    logic           sx;        // result sign (sign of the larger operand, b negated)
    logic [7:0]     ex;        // working exponent
    logic [11:0]    sig_x;     // {carry, hidden, frac[6:0], guard, round, sticky}
    logic [11:0]    sig_y;
    logic [CW-1:0]  cnt;       // remaining alignment shifts
    logic           far;       // exponent gap beyond the cap: Y collapses to sticky
    logic           eff_add;   // magnitudes add when the original signs differ

    // Input classification; exponent 0 is zero (subnormals flushed).
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    assign a_zero = (ea_i == 8'h00);
    assign b_zero = (eb_i == 8'h00);
    assign a_inf  = (ea_i == 8'hFF) && (ma_i == 7'h00);
    assign b_inf  = (eb_i == 8'hFF) && (mb_i == 7'h00);
    assign a_nan  = (ea_i == 8'hFF) && (ma_i != 7'h00);
    assign b_nan  = (eb_i == 8'hFF) && (mb_i != 7'h00);

    logic        a_ge_b;
    logic [7:0]  ediff;
    logic        ediff_far;
    logic [11:0] sig_a, sig_b;
    assign a_ge_b    = ({ea_i, ma_i} >= {eb_i, mb_i});
    assign ediff     = a_ge_b ? (ea_i - eb_i) : (eb_i - ea_i);
    assign ediff_far = (ediff > 8'(ALIGN_MAX));
    assign sig_a     = {2'b01, ma_i, 3'b000};
    assign sig_b     = {2'b01, mb_i, 3'b000};

    // Special-case result, resolved entirely at the accept edge.
    logic        spec;
    logic [15:0] spec_res;
    always_comb begin
        spec     = 1'b1;
        spec_res = 16'h0000;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if (a_inf && b_inf) begin
            // a - b of two Infs cancels when they carry the same sign
            spec_res = (sa_i == sb_i) ? QNAN : {sa_i, 8'hFF, 7'h00};
        end else if (a_inf) begin
            spec_res = {sa_i, 8'hFF, 7'h00};
        end else if (b_inf) begin
            spec_res = {~sb_i, 8'hFF, 7'h00};
        end else if (a_zero && b_zero) begin
            spec_res = {sa_i & ~sb_i, 8'h00, 7'h00};
        end else if (a_zero) begin
            spec_res = {~sb_i, eb_i, mb_i};
        end else if (b_zero) begin
            spec_res = {sa_i, ea_i, ma_i};
        end else begin
            spec = 1'b0;
        end
    end

    // Single-bit shifters; right shifts keep sticky as an OR of everything dropped.
    logic [11:0] y_shr, x_shr, x_shl, sum;
    assign y_shr = {1'b0, sig_y[11:2], sig_y[1] | sig_y[0]};
    assign x_shr = {1'b0, sig_x[11:2], sig_x[1] | sig_x[0]};
    assign x_shl = {sig_x[10:0], 1'b0};
    // X has the larger magnitude, so the subtract never goes negative.
    assign sum   = eff_add ? (sig_x + sig_y) : (sig_x - sig_y);

    // Round to nearest even: up when guard is set and (round|sticky|lsb).
    logic       round_up;
    logic [7:0] frac_r;    // [7] is the mantissa carry-out
    logic [8:0] exp_r;
    assign round_up = sig_x[2] & (sig_x[1] | sig_x[0] | sig_x[3]);
    assign frac_r   = {1'b0, sig_x[9:3]} + {7'd0, round_up};
    assign exp_r    = {1'b0, ex} + {8'd0, frac_r[7]};

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            s_o     <= 1'b0;
            e_o     <= 8'h00;
            m_o     <= 7'h00;
            sx      <= 1'b0;
            ex      <= 8'h00;
            sig_x   <= 12'h000;
            sig_y   <= 12'h000;
            cnt     <= '0;
            far     <= 1'b0;
            eff_add <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        if (spec) begin
                            {s_o, e_o, m_o} <= spec_res;
                            state           <= DONE;
                        end else begin
                            sx      <= a_ge_b ? sa_i : ~sb_i;
                            ex      <= a_ge_b ? ea_i : eb_i;
                            sig_x   <= a_ge_b ? sig_a : sig_b;
                            sig_y   <= a_ge_b ? sig_b : sig_a;
                            cnt     <= ediff_far ? CW'(ALIGN_MAX + 1) : CW'(ediff);
                            far     <= ediff_far;
                            eff_add <= sa_i ^ sb_i;
                            // equal exponents need no alignment cycle at all
                            state   <= (ediff == 8'h00) ? ADD : ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        sig_y <= far ? 12'd1 : y_shr;
                        state <= ADD;
                    end else begin
                        sig_y <= y_shr;
                    end
                end
                ADD: begin
                    if (sum == 12'h000) begin
                        {s_o, e_o, m_o} <= 16'h0000;
                        state           <= DONE;
                    end else begin
                        sig_x <= sum;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (sig_x[11]) begin
                        // carry lands in the hidden bit, so rounding can follow directly
                        sig_x <= x_shr;
                        ex    <= ex + 8'd1;
                        state <= ROUND;
                    end else if (!sig_x[10]) begin
                        if (ex == 8'h01) begin
                            {s_o, e_o, m_o} <= {sx, 8'h00, 7'h00};
                            state           <= DONE;
                        end else begin
                            sig_x <= x_shl;
                            ex    <= ex - 8'd1;
                        end
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    if (exp_r >= 9'h0FF) begin
                        {s_o, e_o, m_o} <= {sx, 8'hFF, 7'h00};
                    end else begin
                        {s_o, e_o, m_o} <= {sx, exp_r[7:0], frac_r[6:0]};
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf16_sub.sv
// tb/tb_bf16_sub.sv - directed scoreboard testbench for bf16_sub
module tb_bf16_sub;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic       sa_i = 1'b0;
    logic [7:0] ea_i = 8'h00;
    logic [6:0] ma_i = 7'h00;
    logic       sb_i = 1'b0;
    logic [7:0] eb_i = 8'h00;
    logic [6:0] mb_i = 7'h00;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic       s_o;
    logic [7:0] e_o;
    logic [6:0] m_o;

    bf16_sub #(.ALIGN_MAX(10)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sa_i    (sa_i),
        .ea_i    (ea_i),
        .ma_i    (ma_i),
        .sb_i    (sb_i),
        .eb_i    (eb_i),
        .mb_i    (mb_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .s_o     (s_o),
        .e_o     (e_o),
        .m_o     (m_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [15:0] bf(input logic s, input logic [7:0] e, input logic [6:0] m);
        return {s, e, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one operand pair, push its expectation, and check it when valid_o rises.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] res, input int lat, input string tag);
        int   cyc;
        bit   busy_bad;
        exp_t e;
        sb_q.push_back('{res: res, lat: lat, tag: tag});
        @(negedge clk);
        check({tag, "_ready_before"}, ready_o, 1);
        valid_i = 1'b1;
        {sa_i, ea_i, ma_i} = a;
        {sb_i, eb_i, mb_i} = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        cyc = 1;
        busy_bad = 1'b0;
        while (valid_o !== 1'b1 && cyc < 40) begin
            if (ready_o !== 1'b0) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (ready_o !== 1'b0) busy_bad = 1'b1;
        e = sb_q.pop_front();
        check({e.tag, "_valid"}, valid_o, 1);
        check({e.tag, "_busy"}, busy_bad, 0);
        check({e.tag, "_res"}, {s_o, e_o, m_o}, e.res);
        check({e.tag, "_lat"}, cyc, e.lat);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hs_valid"}, valid_o, 0);
        check({tag, "_hs_ready"}, ready_o, 1);
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    initial begin
        // reset state
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_out", {s_o, e_o, m_o}, 0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;

        run_op(bf(0, 8'h80, 7'h00), bf(0, 8'h7E, 7'h00), bf(0, 8'h7F, 7'h40), 7, "two_m_half");
        handshake("two_m_half");
        run_op(bf(0, 8'h7F, 7'h00), bf(0, 8'h7F, 7'h00), bf(0, 8'h00, 7'h00), 2, "cancel");
        handshake("cancel");
        run_op(bf(0, 8'h7F, 7'h00), bf(0, 8'h00, 7'h00), bf(0, 8'h7F, 7'h00), 1, "one_m_zero");
        handshake("one_m_zero");
        run_op(bf(1, 8'h00, 7'h00), bf(0, 8'h00, 7'h00), bf(1, 8'h00, 7'h00), 1, "nzero_m_zero");
        handshake("nzero_m_zero");
        run_op(bf(0, 8'h7F, 7'h00), bf(0, 8'h76, 7'h00), bf(0, 8'h7F, 7'h00), 14, "tie_even");
        handshake("tie_even");
        run_op(bf(0, 8'hFF, 7'h00), bf(0, 8'hFF, 7'h00), bf(0, 8'hFF, 7'h40), 1, "inf_m_inf");
        handshake("inf_m_inf");
        run_op(bf(0, 8'hFF, 7'h01), bf(0, 8'h7F, 7'h00), bf(0, 8'hFF, 7'h40), 1, "nan_m_one");
        handshake("nan_m_one");
        run_op(bf(0, 8'h7F, 7'h00), bf(1, 8'hFF, 7'h00), bf(0, 8'hFF, 7'h00), 1, "one_m_ninf");
        handshake("one_m_ninf");
        // alignment boundary: gap of exactly ALIGN_MAX, then beyond it
        run_op(bf(0, 8'h7F, 7'h00), bf(1, 8'h75, 7'h00), bf(0, 8'h7F, 7'h00), 14, "gap_cap");
        handshake("gap_cap");
        run_op(bf(0, 8'h7F, 7'h00), bf(1, 8'h6B, 7'h00), bf(0, 8'h7F, 7'h00), 15, "gap_far_add");
        handshake("gap_far_add");
        run_op(bf(0, 8'h7F, 7'h00), bf(0, 8'h6B, 7'h00), bf(0, 8'h7F, 7'h00), 16, "gap_far_sub");
        handshake("gap_far_sub");
        // exponent overflow to Inf and underflow flush to zero
        run_op(bf(0, 8'hFE, 7'h7F), bf(1, 8'hFE, 7'h7F), bf(0, 8'hFF, 7'h00), 4, "ovf_inf");
        handshake("ovf_inf");
        run_op(bf(0, 8'h01, 7'h10), bf(0, 8'h01, 7'h00), bf(0, 8'h00, 7'h00), 3, "uflow_flush");
        handshake("uflow_flush");

        // backpressure: 3.0 - 1.0 held while inputs wiggle
        run_op(bf(0, 8'h80, 7'h40), bf(0, 8'h7F, 7'h00), bf(0, 8'h80, 7'h00), 5, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_i = ~valid_i;
            {sa_i, ea_i, ma_i} = 16'($urandom);
            {sb_i, eb_i, mb_i} = 16'($urandom);
            @(posedge clk);
            #1;
            check("bp_hold_valid", valid_o, 1);
            check("bp_hold_ready", ready_o, 0);
            check("bp_hold_res", {s_o, e_o, m_o}, bf(0, 8'h80, 7'h00));
        end
        @(negedge clk);
        valid_i = 1'b0;
        handshake("bp");

        // reset abort mid-NORM: 1.0 - 0x7E_7F needs eight left shifts
        @(negedge clk);
        valid_i = 1'b1;
        {sa_i, ea_i, ma_i} = bf(0, 8'h7F, 7'h00);
        {sb_i, eb_i, mb_i} = bf(0, 8'h7E, 7'h7F);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        check("abort_valid", valid_o, 0);
        check("abort_ready", ready_o, 1);
        check("abort_out", {s_o, e_o, m_o}, 0);
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_not_emitted", valid_o, 0);
        end
        run_op(bf(0, 8'h7F, 7'h00), bf(1, 8'h7F, 7'h00), bf(0, 8'h80, 7'h00), 4, "one_m_none");
        handshake("one_m_none");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
